// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared, external, combinational ALU.
// A granted request has its op/a/b registered onto alu_op/alu_a/alu_b.
// The ALU result goes back to the owning requester on the next cycle, through a
// ready/valid response channel.
// A new request can be accepted in the same cycle as the response handshake, so
// with the response ready held high the ALU is kept busy one op per cycle.
// Optional feature macro: ALU_ARB_RR_EN selects round-robin arbitration.
// When the macro is not defined, arbitration is fixed priority and requester 0 wins.

module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,

    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state;
    logic   owner;
`ifdef ALU_ARB_RR_EN
    logic   last_grant;
`endif

    logic              rsp_hs;
    logic              can_accept;
    logic              pick1;
    logic              accept;
    logic [1:0]        grant_v;
    logic [1:0]        req_ready_v;
    logic [1:0]        rsp_valid_v;
    logic [DATA_W-1:0] rsp_data_v [2];

    // The owner's response handshake frees the ALU in the same cycle.
    // This lets the next request go back-to-back with the current response.
    assign rsp_hs     = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
    assign can_accept = (state == IDLE) || rsp_hs;

    // Choose requester 1 when it is the only requester.
    // On a tie it wins only in round-robin mode, and only when requester 0 was granted last.
    always_comb begin
        pick1 = req1_valid && !req0_valid;
`ifdef ALU_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            pick1 = !last_grant;
        end
`endif
    end

    assign grant_v = {req1_valid && pick1, req0_valid && !pick1};
    assign accept  = |req_ready_v;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // Ready is masked while reset is held, so nothing can be accepted during reset.
            assign req_ready_v[gi] = rst_n && can_accept && grant_v[gi];
            assign rsp_valid_v[gi] = (state == RESP) && (owner == (gi == 1));
            assign rsp_data_v[gi]  = rsp_valid_v[gi] ? alu_out : '0;
        end
    endgenerate

    assign req0_ready = req_ready_v[0];
    assign req1_ready = req_ready_v[1];
    assign rsp0_valid = rsp_valid_v[0];
    assign rsp1_valid = rsp_valid_v[1];
    assign rsp0_data  = rsp_data_v[0];
    assign rsp1_data  = rsp_data_v[1];

    // Control FSM and ALU operand registers.
    // Operands change only on an accept, so they stay stable while a response is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant <= 1'b1;
`endif
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            if (accept) begin
                state      <= RESP;
                owner      <= pick1;
`ifdef ALU_ARB_RR_EN
                last_grant <= pick1;
`endif
                alu_op     <= pick1 ? req1_op : req0_op;
                alu_a      <= pick1 ? req1_a  : req0_a;
                alu_b      <= pick1 ? req1_b  : req0_b;
            end else if (rsp_hs) begin
                state <= IDLE;
            end
        end
    end

endmodule
